patch_control_unit: RTL and testbench
=====================================

# patch_control_unit

Patch-side endpoint for instrumented RTL: consumes a module's `observe_port` and `control_port_in` buses and drives its `control_port_out` bus. Default behaviour is transparent passthrough (`control_port_out = control_port_in`). When a programmed observe-bus condition holds for N consecutive cycles, the unit overrides selected control bits with programmed values for a programmed duration. It sits in the SoC patch fabric, one instance per instrumented top-level module, and is configured through a simple write-only valid/ready register port.

## Interface
- `OBS_W`, 5, observe bus width (1..32)
- `CTRL_W`, 8, control bus width (1..32)
- `clk` in 1: sole clock
- `rst_n` in 1: synchronous, active-low reset
- `observe_port` in OBS_W: observed signals from the instrumented module
- `control_port_in` in CTRL_W: native control values from the instrumented module
- `control_port_out` out CTRL_W: possibly-overridden values returned to the instrumented module
- `cfg_valid` in 1: config write request
- `cfg_ready` out 1: config write accepted when high with `cfg_valid`
- `cfg_addr` in 3: register address
- `cfg_data` in 32: write data; bits above field width ignored
- `patch_active` out 1: override currently applied
- `hit_count` out 8: saturating trigger count
- `fsm_state` out 2: IDLE=0, ARMED=1, PATCH=2, DONE=3

## Operation
- Registers:
  - 0 CTRL: bit0 enable, bit1 clear (self-clearing), bit2 oneshot
  - 1 OBS_MASK
  - 2 OBS_VALUE
  - 3 MATCH_COUNT[15:0] (0 treated as 1)
  - 4 OVR_MASK
  - 5 OVR_VALUE
  - 6 HOLD_CYCLES[15:0]: 0 means hold until disabled
  - 7 reserved: write accepted, discarded
- Write fires on `cfg_valid && cfg_ready`.
- `cfg_ready = (fsm_state==IDLE) || (cfg_addr==0)`. Only CTRL is writable outside IDLE.
- Match: `(observe_port & OBS_MASK) == (OBS_VALUE & OBS_MASK)`. All-zero mask matches every cycle.
- FSM transitions:
  - IDLE → ARMED on a CTRL write with enable=1.
  - ARMED: match counter increments on match and clears to 0 on a miss. The cycle giving the MATCH_COUNT-th consecutive match → PATCH, with `hit_count` +1 (saturating at 255).
  - PATCH: hold counter counts cycles in PATCH. After HOLD_CYCLES cycles → DONE if oneshot, else ARMED. With HOLD_CYCLES=0, stays in PATCH until disabled.
  - DONE: passthrough; leaves only on disable.
  - Any state → IDLE on a CTRL write with enable=0.
- Match and hold counters clear on every entry to ARMED or IDLE. Observe activity in PATCH/DONE is ignored.
- Clear bit: zeroes `hit_count` and both counters and forces IDLE, overriding enable in the same write.
- Output: `control_port_out = (control_port_in & ~m) | (OVR_VALUE & m)`, where m = OVR_MASK in PATCH, else 0. Purely combinational from `control_port_in`, with no register in the data path.

## Timing
- Reset values:
  - state IDLE; all config registers 0
  - `patch_active`=0, `hit_count`=0, `fsm_state`=0
  - `cfg_ready`=0 while `rst_n` is low
  - `control_port_out` = `control_port_in`
- Enable write at cycle t: ARMED at t+1, first match sampled at t+1.
- Trigger: N-th consecutive match sampled at cycle t → `patch_active`=1 and override visible from t+1.
- Override lasts exactly HOLD_CYCLES cycles (t+1 .. t+HOLD_CYCLES). Passthrough resumes at t+HOLD_CYCLES+1.
- Re-arm: first new match is sampled in the cycle ARMED is re-entered.
- Disable write at t: `patch_active` drops at t+1. Disable beats a same-cycle trigger or hold expiry.
- Mid-operation reset: next edge returns to IDLE; override removed that cycle.
- `patch_active` and `fsm_state` are registered. `control_port_out` is combinational with 0-cycle latency.

## Structure
- Package `patch_ctrl_pkg` holds:
  - the state enum (IDLE/ARMED/PATCH/DONE, 2-bit)
  - register address constants
  - CTRL bit indices
  - counter width (16)
- Sub-module `patch_trigger_match`: masked compare plus the 16-bit consecutive-match counter. It outputs a one-cycle `fire`, with a clear input driven by the FSM.
- Top level holds the config registers, FSM, hold counter, hit counter and output mux.

## Test plan
- Reset, then drive `control_port_in`=8'hA5 → `control_port_out`=8'hA5, `patch_active`=0, `fsm_state`=0.
- Program mask=5'b00011, value=5'b00001, MATCH_COUNT=3, OVR_MASK=8'h0F, OVR_VALUE=8'h03, HOLD=4; enable. Drive 3 matching cycles with in=8'hA5 → `control_port_out`=8'hA3 for exactly 4 cycles, then 8'hA5; `hit_count`=1; state returns to ARMED.
- Same program with match, match, miss, match, match → no trigger. One further match → trigger.
- Oneshot=1, HOLD=2: trigger → state DONE after 2 cycles. Further matches cause no override and `hit_count` stays 1.
- HOLD=0: override persists 100 cycles. Disable write → passthrough the next cycle, state IDLE.
- Writes to addr 1 while ARMED → `cfg_ready`=0. Trigger and disable in the same cycle → IDLE, no override, `hit_count` unchanged.

Source files
------------

// File: rtl/patch_ctrl_pkg.sv
// Shared types and constants for the patch control unit: FSM state encoding,
// register map, CTRL bit positions and the counter width.
package patch_ctrl_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] ADDR_CTRL        = 3'd0;
    localparam logic [2:0] ADDR_OBS_MASK    = 3'd1;
    localparam logic [2:0] ADDR_OBS_VALUE   = 3'd2;
    localparam logic [2:0] ADDR_MATCH_COUNT = 3'd3;
    localparam logic [2:0] ADDR_OVR_MASK    = 3'd4;
    localparam logic [2:0] ADDR_OVR_VALUE   = 3'd5;
    localparam logic [2:0] ADDR_HOLD_CYCLES = 3'd6;

    localparam int CTRL_ENABLE_BIT  = 0;
    localparam int CTRL_CLEAR_BIT   = 1;
    localparam int CTRL_ONESHOT_BIT = 2;

endpackage

// File: rtl/patch_trigger_match.sv
// Masked observe-bus compare plus a consecutive-match run counter; pulses
// fire on the cycle that completes the programmed run length.
module patch_trigger_match
    import patch_ctrl_pkg::*;
#(
    parameter int OBS_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OBS_W-1:0] observe,
    input  logic [OBS_W-1:0] obs_mask,
    input  logic [OBS_W-1:0] obs_value,
    input  logic [CNT_W-1:0] match_count,
    input  logic             clr,
    output logic             fire
);

    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] target;
    logic             match;

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        match  = ((observe ^ obs_value) & obs_mask) == '0;
        target = (match_count == '0) ? CNT_W'(1) : match_count;
        fire   = 1'b0;
        run_d  = '0;
        if (!clr && match) begin
            if (run_q == target - CNT_W'(1)) fire = 1'b1;
            else                             run_d = run_q + CNT_W'(1);
        end
    end

    // NOTE: flops use <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) run_q <= '0;
        else        run_q <= run_d;
    end

endmodule

// File: rtl/patch_control_unit.sv
// Patch endpoint: passes control_port_in through, and overrides masked bits for
// a programmed time once the observe-bus trigger has matched N cycles in a row.
module patch_control_unit
    import patch_ctrl_pkg::*;
#(
    parameter int OBS_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OBS_W-1:0]  observe_port,
    input  logic [CTRL_W-1:0] control_port_in,
    output logic [CTRL_W-1:0] control_port_out,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_addr,
    input  logic [31:0]       cfg_data,
    output logic              patch_active,
    output logic [7:0]        hit_count,
    output logic [1:0]        fsm_state
);

    state_e            state_q, state_d;
    logic [OBS_W-1:0]  obs_mask_q, obs_mask_d, obs_value_q, obs_value_d;
    logic [CNT_W-1:0]  match_count_q, match_count_d, hold_cycles_q, hold_cycles_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [CTRL_W-1:0] ovr_mask_q, ovr_mask_d, ovr_value_q, ovr_value_d;
    logic              oneshot_q, oneshot_d, patch_active_q, patch_active_d;
    logic [7:0]        hit_count_q, hit_count_d;
    logic              cfg_fire, ctrl_wr, kill, match_clr, fire;
    logic [CTRL_W-1:0] ovr_m;
    logic              unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data;

    // Kill covers both disable and clear; it outranks trigger and hold expiry.
    always_comb begin
        cfg_ready = rst_n && ((state_q == ST_IDLE) || (cfg_addr == ADDR_CTRL));
        cfg_fire  = cfg_valid && cfg_ready;
        ctrl_wr   = cfg_fire && (cfg_addr == ADDR_CTRL);
        kill      = ctrl_wr && (cfg_data[CTRL_CLEAR_BIT] || !cfg_data[CTRL_ENABLE_BIT]);
        match_clr = (state_q != ST_ARMED) || kill;
    end

    patch_trigger_match #(.OBS_W(OBS_W)) u_match (
        .clk         (clk),
        .rst_n       (rst_n),
        .observe     (observe_port),
        .obs_mask    (obs_mask_q),
        .obs_value   (obs_value_q),
        .match_count (match_count_q),
        .clr         (match_clr),
        .fire        (fire)
    );

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = '0;
        hit_count_d   = hit_count_q;
        obs_mask_d    = obs_mask_q;
        obs_value_d   = obs_value_q;
        match_count_d = match_count_q;
        ovr_mask_d    = ovr_mask_q;
        ovr_value_d   = ovr_value_q;
        hold_cycles_d = hold_cycles_q;
        oneshot_d     = oneshot_q;

        if (cfg_fire) begin
            case (cfg_addr)
                ADDR_CTRL:        oneshot_d     = cfg_data[CTRL_ONESHOT_BIT];
                ADDR_OBS_MASK:    obs_mask_d    = cfg_data[OBS_W-1:0];
                ADDR_OBS_VALUE:   obs_value_d   = cfg_data[OBS_W-1:0];
                ADDR_MATCH_COUNT: match_count_d = cfg_data[CNT_W-1:0];
                ADDR_OVR_MASK:    ovr_mask_d    = cfg_data[CTRL_W-1:0];
                ADDR_OVR_VALUE:   ovr_value_d   = cfg_data[CTRL_W-1:0];
                ADDR_HOLD_CYCLES: hold_cycles_d = cfg_data[CNT_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr && cfg_data[CTRL_ENABLE_BIT]) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (fire) begin
                    state_d = ST_PATCH;
                    if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
                end
            end
            ST_PATCH: begin
                // A zero hold count never expires; the override stays until disabled.
                if (hold_cycles_q != '0) begin
                    if (hold_cnt_q == hold_cycles_q - CNT_W'(1))
                        state_d = oneshot_q ? ST_DONE : ST_ARMED;
                    else
                        hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (kill) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
        end
        if (ctrl_wr && cfg_data[CTRL_CLEAR_BIT]) hit_count_d = '0;

        patch_active_d = (state_d == ST_PATCH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            hold_cnt_q     <= '0;
            hit_count_q    <= '0;
            obs_mask_q     <= '0;
            obs_value_q    <= '0;
            match_count_q  <= '0;
            ovr_mask_q     <= '0;
            ovr_value_q    <= '0;
            hold_cycles_q  <= '0;
            oneshot_q      <= 1'b0;
            patch_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            hit_count_q    <= hit_count_d;
            obs_mask_q     <= obs_mask_d;
            obs_value_q    <= obs_value_d;
            match_count_q  <= match_count_d;
            ovr_mask_q     <= ovr_mask_d;
            ovr_value_q    <= ovr_value_d;
            hold_cycles_q  <= hold_cycles_d;
            oneshot_q      <= oneshot_d;
            patch_active_q <= patch_active_d;
        end
    end

    always_comb begin
        ovr_m            = patch_active_q ? ovr_mask_q : '0;
        control_port_out = (control_port_in & ~ovr_m) | (ovr_value_q & ovr_m);
        patch_active     = patch_active_q;
        hit_count        = hit_count_q;
        fsm_state        = state_q;
    end

endmodule

// File: tb/tb_patch_control_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural model of the patch unit.
module tb_patch_control_unit;

    localparam int OBS_W  = 5;
    localparam int CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [OBS_W-1:0]  observe_port = '0;
    logic [CTRL_W-1:0] control_port_in = '0;
    logic [CTRL_W-1:0] control_port_out;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_addr = '0;
    logic [31:0]       cfg_data = '0;
    logic              patch_active;
    logic [7:0]        hit_count;
    logic [1:0]        fsm_state;

    always #5 clk = ~clk;

    patch_control_unit #(.OBS_W(OBS_W), .CTRL_W(CTRL_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .observe_port     (observe_port),
        .control_port_in  (control_port_in),
        .control_port_out (control_port_out),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .patch_active     (patch_active),
        .hit_count        (hit_count),
        .fsm_state        (fsm_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 waiting for a run, 2 overriding, 3 finished.
    int               m_mode, m_run, m_left, m_hits, m_need, m_hold;
    logic [OBS_W-1:0] m_omask, m_oval;
    logic [CTRL_W-1:0] m_vmask, m_vval;
    bit               m_oneshot;
    bit               m_wr, m_ctrl, m_kill, m_hit;
    bit               chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_run = 0; m_left = 0; m_hits = 0; m_need = 0; m_hold = 0;
            m_omask = '0; m_oval = '0; m_vmask = '0; m_vval = '0; m_oneshot = 1'b0;
        end else begin
            m_wr   = cfg_valid && (m_mode == 0 || cfg_addr == 3'd0);
            m_ctrl = m_wr && cfg_addr == 3'd0;
            m_kill = m_ctrl && (cfg_data[1] || !cfg_data[0]);
            m_hit  = (observe_port & m_omask) == (m_oval & m_omask);
            if (m_kill) begin
                m_mode = 0; m_run = 0;
            end else begin
                case (m_mode)
                    0: if (m_ctrl && cfg_data[0]) begin m_mode = 1; m_run = 0; end
                    1: begin
                        m_run = m_hit ? m_run + 1 : 0;
                        if (m_run >= ((m_need == 0) ? 1 : m_need)) begin
                            m_mode = 2; m_run = 0; m_left = m_hold;
                            if (m_hits < 255) m_hits++;
                        end
                    end
                    2: if (m_hold != 0) begin
                        m_left--;
                        if (m_left == 0) begin m_mode = m_oneshot ? 3 : 1; m_run = 0; end
                    end
                    default: ;
                endcase
            end
            if (m_ctrl && cfg_data[1]) m_hits = 0;
            if (m_wr) begin
                case (cfg_addr)
                    3'd0: m_oneshot = cfg_data[2];
                    3'd1: m_omask   = cfg_data[OBS_W-1:0];
                    3'd2: m_oval    = cfg_data[OBS_W-1:0];
                    3'd3: m_need    = int'(cfg_data[15:0]);
                    3'd4: m_vmask   = cfg_data[CTRL_W-1:0];
                    3'd5: m_vval    = cfg_data[CTRL_W-1:0];
                    3'd6: m_hold    = int'(cfg_data[15:0]);
                    default: ;
                endcase
            end
        end
    end

    logic [CTRL_W-1:0] exp_m;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_m = (m_mode == 2) ? m_vmask : '0;
            check("out",    32'(control_port_out), 32'((control_port_in & ~exp_m) | (m_vval & exp_m)));
            check("active", 32'(patch_active),     32'(m_mode == 2));
            check("state",  32'(fsm_state),        32'(m_mode));
            check("hits",   32'(hit_count),        32'(m_hits));
            check("ready",  32'(cfg_ready),        32'(rst_n && (m_mode == 0 || cfg_addr == 3'd0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    endtask

    localparam logic [OBS_W-1:0] OBS_HIT  = 5'b00001;
    localparam logic [OBS_W-1:0] OBS_MISS = 5'b00000;

    logic [4:0]  seq;
    logic [31:0] r;
    int          a;

    initial begin
        control_port_in = 8'hA5;
        repeat (3) tick();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        @(negedge clk);
        check("rst_out", 32'(control_port_out), 32'hA5);
        check("rst_active", 32'(patch_active), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        tick();

        // Basic trigger: 3 matches, 4-cycle override of the low nibble.
        wr(3'd1, 32'h03); wr(3'd2, 32'h01); wr(3'd3, 32'd3);
        wr(3'd4, 32'h0F); wr(3'd5, 32'h03); wr(3'd6, 32'd4);
        wr(3'd0, 32'h1);
        observe_port = OBS_HIT;
        repeat (3) tick();
        observe_port = OBS_MISS;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_out", 32'(control_port_out), 32'hA3);
            tick();
        end
        @(negedge clk);
        check("after_out", 32'(control_port_out), 32'hA5);
        check("after_state", 32'(fsm_state), 32'd1);
        check("after_hits", 32'(hit_count), 32'd1);

        // A miss restarts the run.
        seq = 5'b11011;
        for (int i = 4; i >= 0; i--) begin
            observe_port = seq[i] ? OBS_HIT : OBS_MISS;
            tick();
        end
        @(negedge clk);
        check("broken_run_state", 32'(fsm_state), 32'd1);
        observe_port = OBS_HIT;
        tick();
        @(negedge clk);
        check("run_trig_state", 32'(fsm_state), 32'd2);
        check("run_trig_hits", 32'(hit_count), 32'd2);
        observe_port = OBS_MISS;
        repeat (4) tick();

        // Oneshot with a 2-cycle hold ends in DONE.
        wr(3'd0, 32'h0); wr(3'd0, 32'h2); wr(3'd6, 32'd2); wr(3'd0, 32'h5);
        observe_port = OBS_HIT;
        repeat (3) tick();
        observe_port = OBS_MISS;
        @(negedge clk); check("os_state1", 32'(fsm_state), 32'd2);
        tick();
        @(negedge clk); check("os_state2", 32'(fsm_state), 32'd2);
        tick();
        @(negedge clk);
        check("os_done", 32'(fsm_state), 32'd3);
        check("os_hits", 32'(hit_count), 32'd1);
        observe_port = OBS_HIT;
        repeat (5) tick();
        @(negedge clk);
        check("done_state", 32'(fsm_state), 32'd3);
        check("done_hits", 32'(hit_count), 32'd1);
        check("done_out", 32'(control_port_out), 32'hA5);

        // Zero hold: override persists until disabled.
        wr(3'd0, 32'h0); wr(3'd6, 32'd0); wr(3'd0, 32'h1);
        observe_port = OBS_HIT;
        repeat (3) tick();
        observe_port = OBS_MISS;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("inf_out", 32'(control_port_out), 32'hA3);
            tick();
        end
        wr(3'd0, 32'h0);
        @(negedge clk);
        check("dis_out", 32'(control_port_out), 32'hA5);
        check("dis_state", 32'(fsm_state), 32'd0);

        // Non-CTRL write refused while ARMED; disable beats a same-cycle trigger.
        wr(3'd6, 32'd4); wr(3'd0, 32'h1);
        cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 32'h1F;
        @(negedge clk);
        check("armed_ready", 32'(cfg_ready), 32'd0);
        tick();
        cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        observe_port = OBS_HIT;
        repeat (2) tick();
        wr(3'd0, 32'h0);
        observe_port = OBS_MISS;
        @(negedge clk);
        check("race_state", 32'(fsm_state), 32'd0);
        check("race_active", 32'(patch_active), 32'd0);
        check("race_hits", 32'(hit_count), 32'd2);

        // Saturation: MATCH_COUNT=0 acts as 1, zero mask matches every cycle.
        wr(3'd0, 32'h2); wr(3'd3, 32'd0); wr(3'd6, 32'd1); wr(3'd1, 32'd0);
        wr(3'd0, 32'h1);
        repeat (600) tick();
        @(negedge clk);
        check("sat_hits", 32'(hit_count), 32'd255);
        wr(3'd0, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom;
            control_port_in = r[CTRL_W-1:0];
            r = $urandom;
            if ($urandom_range(0, 99) < 70)
                observe_port = (m_oval & m_omask) | (r[OBS_W-1:0] & ~m_omask);
            else
                observe_port = r[OBS_W-1:0];
            cfg_valid = ($urandom_range(0, 99) < 6);
            a = int'($urandom_range(0, 9));
            cfg_addr = (a > 7) ? 3'd0 : 3'(a);
            case (cfg_addr)
                3'd3, 3'd6: cfg_data = 32'($urandom_range(0, 6));
                3'd0: begin
                    cfg_data = 32'($urandom_range(0, 7));
                    if ($urandom_range(0, 3) != 0) cfg_data[1] = 1'b0;
                end
                default: cfg_data = $urandom;
            endcase
            rst_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        cfg_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
